// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    // Loader FSM states; encoding is fixed so it reads the same in waveforms.
    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    // Stream bytes per 32-bit word (length field and instruction words alike).
    localparam int BYTES_PER_WORD = 4;

    // A length is loadable when it is non-zero and fits in the memory.
    function automatic logic len_is_valid(input logic [31:0] len, input int max_words);
        return (len != 32'd0) && (len <= $unsigned(max_words));
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects four little-endian stream bytes into one 32-bit word and pulses
// word_valid on the handshake that delivers the fourth byte.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_fire,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    // Only lanes 0..2 need storage: lane 3 arrives on the same cycle the word
    // is consumed and is taken straight from in_data.
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] asm_q, asm_d;

    // Next byte counter and lane write for each accepted byte.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        if (clear) begin
            byte_cnt_d = 2'd0;
        end else if (in_fire) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    asm_d[7:0]   = in_data;
                2'd1:    asm_d[15:8]  = in_data;
                2'd2:    asm_d[23:16] = in_data;
                default: asm_d        = asm_q;
            endcase
        end
    end

    // Counter and assembly register; reset discards any partial word.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            byte_cnt_q <= 2'd0;
            // NOTE: the partial word is cleared on reset so no stale lane can survive into a new load.
            asm_q      <= 24'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

    // Completed word is visible during the fourth-byte handshake.
    always_comb begin
        word       = {in_data, asm_q};
        word_valid = in_fire && (byte_cnt_q == LAST_LANE);
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a word count and that many instruction words over
// a byte stream, writes them to sequential instruction-memory addresses and
// releases the core from reset once the whole image is in place.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int MAX_WORDS = 2 ** ADDR_WIDTH;
    localparam int CW        = ADDR_WIDTH + 1;

    state_e state_q, state_d;

    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         word_idx_q, word_idx_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic        in_fire;
    logic        reload_ok;
    logic        last_word;
    logic [31:0] asm_word;
    logic        asm_valid;

    // Handshake and control qualifiers shared by the FSM and datapath.
    always_comb begin
        in_fire   = in_valid && in_ready;
        reload_ok = reload && ((state_q == S_DONE) || (state_q == S_ERR));
        last_word = (word_idx_q == (len_q - CW'(1)));
    end

    // One assembler serves both the length field and the instruction words.
    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (reload_ok),
        .in_fire    (in_fire),
        .in_data    (in_data),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN: begin
                if (asm_valid) begin
                    state_d = len_is_valid(asm_word, MAX_WORDS) ? S_DATA : S_ERR;
                end
            end
            S_DATA: begin
                if (asm_valid && last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (reload_ok) begin
                    state_d = S_LEN;
                end
            end
            default: state_d = S_LEN;
        endcase
    end

    // FSM outputs: the core stays in reset until a complete load.
    always_comb begin
        in_ready     = ((state_q == S_LEN) || (state_q == S_DATA)) && !rst;
        core_rst     = (state_q != S_DONE);
        load_done    = (state_q == S_DONE);
        load_err     = (state_q == S_ERR);
        words_loaded = word_idx_q;
    end

    // Length capture, word index and write-port staging.
    always_comb begin
        len_d      = len_q;
        word_idx_d = word_idx_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_LEN: begin
                if (asm_valid) begin
                    len_d      = asm_word[CW-1:0];
                    word_idx_d = '0;
                end
            end
            S_DATA: begin
                // The write port is its own register, so the assembler is
                // free to take the next byte on the very next cycle.
                if (asm_valid) begin
                    we_d       = 1'b1;
                    waddr_d    = word_idx_q[ADDR_WIDTH-1:0];
                    wdata_d    = asm_word;
                    word_idx_d = word_idx_q + CW'(1);
                end
            end
            default: begin
                if (reload_ok) begin
                    len_d      = '0;
                    word_idx_d = '0;
                end
            end
        endcase
    end

    // Datapath registers; reset also cancels a write staged on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            word_idx_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Write port drive.
    always_comb begin
        imem_we    = we_q;
        imem_waddr = waddr_q;
        imem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: full-rate and gapped loads, bad lengths,
// mid-load reset and reload.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    int n_assert = 0;
    int n_fail   = 0;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic chk_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_we"},    32'(imem_we),    32'd1);
        chk({tag, "_waddr"}, 32'(imem_waddr), addr);
        chk({tag, "_wdata"}, imem_wdata,      data);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        reload   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();

        // Reset values
        chk("rst_in_ready",  32'(in_ready),     32'd0);
        chk("rst_we",        32'(imem_we),      32'd0);
        chk("rst_waddr",     32'(imem_waddr),   32'd0);
        chk("rst_wdata",     imem_wdata,        32'd0);
        chk("rst_core_rst",  32'(core_rst),     32'd1);
        chk("rst_done",      32'(load_done),    32'd0);
        chk("rst_err",       32'(load_err),     32'd0);
        chk("rst_words",     32'(words_loaded), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready),     32'd1);

        // 1: len=2, full-rate stream
        send_word(32'd2);
        chk("t1_len_no_we",  32'(imem_we),      32'd0);
        chk("t1_len_done",   32'(load_done),    32'd0);
        send_word(32'h0050_0013);
        chk_write("t1_w0", 32'd0, 32'h0050_0013);
        chk("t1_w0_words",   32'(words_loaded), 32'd1);
        chk("t1_w0_corerst", 32'(core_rst),     32'd1);
        chk("t1_w0_done",    32'(load_done),    32'd0);
        send_byte(8'h93);
        chk("t1_gap_we",     32'(imem_we),      32'd0);
        send_byte(8'h00);
        send_byte(8'hA0);
        send_byte(8'h00);
        chk_write("t1_w1", 32'd1, 32'h00A0_0093);
        chk("t1_done",       32'(load_done),    32'd1);
        chk("t1_corerst",    32'(core_rst),     32'd0);
        chk("t1_words",      32'(words_loaded), 32'd2);
        chk("t1_in_ready",   32'(in_ready),     32'd0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_valid = 1'b0;
        chk("t1_post_we",    32'(imem_we),      32'd0);
        chk("t1_post_done",  32'(load_done),    32'd1);
        chk("t1_post_words", 32'(words_loaded), 32'd2);

        // 2: same stream with a 3-cycle gap mid-word
        pulse_reload();
        chk("t2_corerst",    32'(core_rst),     32'd1);
        chk("t2_done_clr",   32'(load_done),    32'd0);
        chk("t2_words_clr",  32'(words_loaded), 32'd0);
        chk("t2_in_ready",   32'(in_ready),     32'd1);
        send_word(32'd2);
        send_byte(8'h13);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_gap_we", 32'(imem_we), 32'd0);
        end
        send_byte(8'h50);
        chk("t2_mid_we",     32'(imem_we),      32'd0);
        send_byte(8'h00);
        chk_write("t2_w0", 32'd0, 32'h0050_0013);
        send_word(32'h00A0_0093);
        chk_write("t2_w1", 32'd1, 32'h00A0_0093);
        chk("t2_done",       32'(load_done),    32'd1);
        chk("t2_words",      32'(words_loaded), 32'd2);

        // 3: len=0
        pulse_reload();
        send_word(32'd0);
        chk("t3_err",        32'(load_err),     32'd1);
        chk("t3_in_ready",   32'(in_ready),     32'd0);
        chk("t3_we",         32'(imem_we),      32'd0);
        chk("t3_corerst",    32'(core_rst),     32'd1);
        chk("t3_done",       32'(load_done),    32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        chk("t3_hold_err",   32'(load_err),     32'd1);
        chk("t3_hold_we",    32'(imem_we),      32'd0);

        // 4: len=MAX_WORDS+1 rejected; len=MAX_WORDS accepted
        pulse_reload();
        chk("t4_err_clr",    32'(load_err),     32'd0);
        send_word(32'h0000_0401);
        chk("t4_err",        32'(load_err),     32'd1);
        chk("t4_we",         32'(imem_we),      32'd0);
        chk("t4_words",      32'(words_loaded), 32'd0);
        pulse_reload();
        send_word(32'h0000_0400);
        chk("t4_max_err",    32'(load_err),     32'd0);
        chk("t4_max_ready",  32'(in_ready),     32'd1);

        // 5: reset mid-load, then a clean len=1 load
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_word(32'd3);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        tick();
        chk("t5_in_ready",   32'(in_ready),     32'd0);
        chk("t5_we",         32'(imem_we),      32'd0);
        chk("t5_waddr",      32'(imem_waddr),   32'd0);
        chk("t5_wdata",      imem_wdata,        32'd0);
        chk("t5_corerst",    32'(core_rst),     32'd1);
        chk("t5_done",       32'(load_done),    32'd0);
        chk("t5_err",        32'(load_err),     32'd0);
        chk("t5_words",      32'(words_loaded), 32'd0);
        rst = 1'b0;
        send_word(32'd1);
        send_word(32'h1234_5678);
        chk_write("t5_w0", 32'd0, 32'h1234_5678);
        chk("t5_done_1",     32'(load_done),    32'd1);
        chk("t5_words_1",    32'(words_loaded), 32'd1);

        // 6: reload after success, len=1 with 0xDEADBEEF
        pulse_reload();
        chk("t6_corerst",    32'(core_rst),     32'd1);
        chk("t6_done_clr",   32'(load_done),    32'd0);
        chk("t6_words_clr",  32'(words_loaded), 32'd0);
        send_word(32'd1);
        pulse_reload();
        chk("t6_ign_ready",  32'(in_ready),     32'd1);
        send_word(32'hDEAD_BEEF);
        chk_write("t6_w0", 32'd0, 32'hDEAD_BEEF);
        chk("t6_done",       32'(load_done),    32'd1);
        chk("t6_corerst_0",  32'(core_rst),     32'd0);
        chk("t6_words",      32'(words_loaded), 32'd1);
        tick();
        chk("t6_post_we",    32'(imem_we),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the core's instruction memory.
- Accepts a byte stream over a valid/ready handshake: a 4-byte little-endian word count N, then N instruction words, each sent as 4 bytes LSB first.
- Assembles 32-bit words and drives the instruction-memory write port with sequential word addresses.
- Holds the processor core in reset until the load completes successfully.

Parameters:
- ADDR_WIDTH, 10, word-address width of the instruction memory write port; MAX_WORDS = 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle. A byte transfers when in_valid && in_ready.
- reload  input  1  single-cycle request to start a new load; honoured only in S_DONE or S_ERR.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_waddr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  instruction word.
- core_rst  output  1  reset to the processor core, active-high.
- load_done  output  1  level; successful load complete.
- load_err  output  1  level; bad length received.
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current load.

Behaviour:
- Reset values, held while rst=1 and taking effect on the clock edge:
  - state=S_LEN, byte_cnt=0, len=0, word_idx=0.
  - in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - core_rst=1, load_done=0, load_err=0, words_loaded=0.
- in_ready is combinational: (state==S_LEN || state==S_DATA) && !rst.
- byte_cnt (2 bits) counts accepted bytes within the current 4-byte group. It wraps 3->0.
- Byte lane k = byte_cnt: each accepted byte is written into bits [8k+7:8k] of the assembly register.
- S_LEN, collecting the 4 length bytes:
  - When the 4th length byte is accepted, evaluate len.
  - len==0 or len>MAX_WORDS: go to S_ERR.
  - Otherwise go to S_DATA with word_idx=0.
- S_DATA, on acceptance of the 4th byte of a word:
  - The next cycle drives imem_we=1, imem_wdata = assembled word, imem_waddr = word_idx.
  - word_idx and words_loaded increment at that same edge.
  - Latency: exactly 1 cycle from the 4th-byte handshake to the imem_we cycle.
  - imem_we is low in every other cycle.
  - The write port register is separate from the assembly register, so back-to-back bytes at full rate are sustained with no stall.
  - When the handshake completes word number len (word_idx == len-1), go to S_DONE. The final write still issues in the following cycle.
- S_DONE:
  - in_ready=0.
  - load_done=1 and core_rst=0, both asserted in the same cycle as the final imem_we.
  - Any in_valid is ignored; no bytes are consumed.
- S_ERR:
  - in_ready=0, load_err=1, core_rst stays 1, imem_we=0.
- reload=1 in S_DONE or S_ERR:
  - Next state S_LEN.
  - core_rst=1, load_done=0, load_err=0, words_loaded=0, byte_cnt=0, word_idx=0.
- reload in S_LEN or S_DATA is ignored.
- Address wrap: not possible, because len<=MAX_WORDS is enforced. imem_waddr never exceeds MAX_WORDS-1.
- rst mid-load: the partial word and the length are discarded, and any pending imem_we is cancelled (forced 0).
- rst and reload together: rst wins.
- in_valid with in_ready=0: no state change. The upstream source holds its data.

Decomposition:
- Shared package:
  - State encoding: S_LEN=2'd0, S_DATA=2'd1, S_DONE=2'd2, S_ERR=2'd3.
  - Byte-group constant BYTES_PER_WORD=4.
- Sub-module byte_assembler: shift-in of 4 bytes into a 32-bit word, with a word_valid pulse on the 4th byte. It is natural and reusable for the length field and the data words.
- FSM, address counter and write port live in imem_loader.

Test Plan:
1. Len=2, then bytes 13 00 50 00, 93 00 A0 00 at full rate:
   - Writes (addr0, 0x00500013) and (addr1, 0x00A00093), each 1 cycle after its 4th byte.
   - load_done=1 and core_rst=0 in the cycle of the second write; words_loaded=2.
2. Same stream with in_valid deasserted for 3 cycles mid-word:
   - Identical writes and data.
   - No imem_we during the gap; byte_cnt is held.
3. Len=0:
   - S_ERR; load_err=1; in_ready=0; no imem_we; core_rst stays 1.
4. Len=MAX_WORDS+1 (0x401 for ADDR_WIDTH=10):
   - S_ERR immediately after the 4th length byte; no writes.
5. rst pulsed after 2 bytes of word 1 of a 3-word load:
   - All outputs return to reset values.
   - A new full load of len=1 writes addr0 correctly; the stale bytes are not merged.
6. After a successful load, pulse reload and send len=1 with word 0xDEADBEEF:
   - core_rst rises the cycle after reload.
   - The single write goes to addr0; load_done re-asserts.
